// File: rtl/hf_reader_rx_framer.sv
// -----------------------------------------------------------------------------
// hf_reader_rx_framer
// ISO14443-A reader-side receive/transmit front end for the HF FPGA image.
//   Receive : filters ADC samples, detects tag load modulation once per
//             subcarrier bit slot (SC_DIV carrier cycles).
//   Framing : packs detected bits into FRAME_BITS-wide words and streams them
//             MSB-first to the ARM over SSP, generating ssp_clk/ssp_frame.
//   Transmit: registers the ARM modulation bit and gates the carrier.
//
// Build option:
//   HF_RX_FILTER_EN  defined   -> 5-tap derivative filter (2*p4+p3)-(2*adc+p1)
//                    undefined -> first difference p1-adc (p2..p4 not built)
//
// Ports:
//   ck_1356meg  in   13.56 MHz carrier clock, all logic on its rising edge
//   nrst        in   synchronous reset, active low
//   adc_d       in   unsigned ADC sample (ADC_W)
//   threshold   in   unsigned edge threshold (ADC_W), quasi-static
//   mode        in   3'b011 listen, 3'b100 modulate, others idle
//   ssp_dout    in   modulation bit from ARM (1 = pause)
//   ssp_clk     out  SSP bit clock
//   ssp_frame   out  SSP frame marker
//   ssp_din     out  serial data to ARM
//   pwr_hi      out  gated carrier to HF driver (only combinational output)
//   curbit      out  last detector decision (debug)
// -----------------------------------------------------------------------------
module hf_reader_rx_framer #(
  parameter int unsigned ADC_W       = 8,
  parameter int unsigned SC_DIV      = 16,
  parameter int unsigned FRAME_BITS  = 8,
  parameter int unsigned RESET_PHASE = 3
) (
  input  logic             ck_1356meg,
  input  logic             nrst,
  input  logic [ADC_W-1:0] adc_d,
  input  logic [ADC_W-1:0] threshold,
  input  logic [2:0]       mode,
  input  logic             ssp_dout,
  output logic             ssp_clk,
  output logic             ssp_frame,
  output logic             ssp_din,
  output logic             pwr_hi,
  output logic             curbit
);

  localparam int unsigned PERIOD = SC_DIV * FRAME_BITS;
  localparam int unsigned CNT_W  = $clog2(PERIOD);
  localparam int unsigned SLOT_W = $clog2(SC_DIV);
  localparam int unsigned BIDX_W = CNT_W - SLOT_W;
  localparam int unsigned FILT_W = ADC_W + 3;

  localparam logic [2:0] MODE_LISTEN = 3'b011;
  localparam logic [2:0] MODE_MOD    = 3'b100;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  FRAME_SET = CNT_W'(SC_DIV / 2 - 1);
  localparam logic [CNT_W-1:0]  FRAME_CLR = CNT_W'(SC_DIV + SC_DIV / 2 - 1);
  localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(SC_DIV / 2);
  localparam logic [SLOT_W-1:0] SLOT_EVAL = SLOT_W'(RESET_PHASE);
  localparam logic [BIDX_W-1:0] BIDX_TOP  = BIDX_W'(FRAME_BITS - 1);

  logic [CNT_W-1:0]         cnt;
  logic [SLOT_W-1:0]        slot_c;
  logic [BIDX_W-1:0]        bidx_c;
  logic [BIDX_W-1:0]        bit_sel_c;
  logic                     frame_start_c;
  logic                     slot_start_c;

  logic [ADC_W-1:0]         p1;
  logic signed [FILT_W-1:0] filt_c;
  logic                     filt_pos_c;
  logic signed [FILT_W-1:0] fall_max;
  logic signed [FILT_W-1:0] rise_min;
  logic signed [FILT_W-1:0] thr_pos_c;
  logic signed [FILT_W-1:0] thr_neg_c;

  logic                     rxbit_c;
  logic [FRAME_BITS-1:0]    asm_word;
  logic [FRAME_BITS-1:0]    tx_word;
  logic [FRAME_BITS-1:0]    tx_word_nxt_c;
  logic                     mod_sig_coil;

  // Slot/bit decomposition; SC_DIV is a power of two so this is a plain split.
  assign slot_c        = cnt[SLOT_W-1:0];
  assign bidx_c        = cnt[CNT_W-1:SLOT_W];
  assign bit_sel_c     = BIDX_TOP - bidx_c;
  assign frame_start_c = (cnt == '0);
  assign slot_start_c  = (slot_c == '0);

  // Frame counter: 0 .. SC_DIV*FRAME_BITS-1, then wrap.
  always_ff @(posedge ck_1356meg) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef HF_RX_FILTER_EN
  logic [ADC_W-1:0]  p2;
  logic [ADC_W-1:0]  p3;
  logic [ADC_W-1:0]  p4;
  logic [FILT_W-1:0] tap_old_c;
  logic [FILT_W-1:0] tap_new_c;

  // Sample history for the derivative filter.
  always_ff @(posedge ck_1356meg) begin
    if (!nrst) begin
      p1 <= '0;
      p2 <= '0;
      p3 <= '0;
      p4 <= '0;
    end else begin
      p1 <= adc_d;
      p2 <= p1;
      p3 <= p2;
      p4 <= p3;
    end
  end

  // Zero-extended taps; the difference always fits in FILT_W signed bits.
  assign tap_old_c = {2'b00, p4, 1'b0} + {3'b000, p3};
  assign tap_new_c = {2'b00, adc_d, 1'b0} + {3'b000, p1};
  assign filt_c    = $signed(tap_old_c - tap_new_c);
`else
  // Single-sample history for the first-difference filter.
  always_ff @(posedge ck_1356meg) begin
    if (!nrst) begin
      p1 <= '0;
    end else begin
      p1 <= adc_d;
    end
  end

  assign filt_c = $signed({3'b000, p1} - {3'b000, adc_d});
`endif

  // Positive means a falling ADC edge; zero counts toward the rise side.
  assign filt_pos_c = ~filt_c[FILT_W-1] & (|filt_c);

  assign thr_pos_c = $signed({3'b000, threshold});
  assign thr_neg_c = -thr_pos_c;

  // Peak tracker: decide and clear once per slot, otherwise track extremes.
  always_ff @(posedge ck_1356meg) begin
    if (!nrst) begin
      fall_max <= '0;
      rise_min <= '0;
      curbit   <= 1'b0;
    end else if (slot_c == SLOT_EVAL) begin
      curbit   <= (fall_max > thr_pos_c) && (rise_min < thr_neg_c);
      fall_max <= '0;
      rise_min <= '0;
    end else begin
      if (filt_pos_c && (filt_c > fall_max)) begin
        fall_max <= filt_c;
      end
      if (!filt_pos_c && (filt_c < rise_min)) begin
        rise_min <= filt_c;
      end
    end
  end

  // Only listen mode feeds detections into the frame; idle streams zeros.
  assign rxbit_c = curbit & (mode == MODE_LISTEN);

  // The word handed off at frame start is the pre-update assembly register.
  assign tx_word_nxt_c = frame_start_c ? asm_word : tx_word;

  // Word assembly, handoff and MSB-first serialisation.
  always_ff @(posedge ck_1356meg) begin
    if (!nrst) begin
      asm_word <= '0;
      tx_word  <= '0;
      ssp_din  <= 1'b0;
    end else begin
      if (frame_start_c) begin
        tx_word <= asm_word;
      end
      if (slot_start_c) begin
        asm_word[bit_sel_c] <= rxbit_c;
        ssp_din             <= tx_word_nxt_c[bit_sel_c];
      end
    end
  end

  // SSP bit clock (high for the first half of each slot) and frame marker.
  always_ff @(posedge ck_1356meg) begin
    if (!nrst) begin
      ssp_clk   <= 1'b0;
      ssp_frame <= 1'b0;
    end else begin
      if (slot_start_c) begin
        ssp_clk <= 1'b1;
      end else if (slot_c == SLOT_HALF) begin
        ssp_clk <= 1'b0;
      end
      if (cnt == FRAME_SET) begin
        ssp_frame <= 1'b1;
      end else if (cnt == FRAME_CLR) begin
        ssp_frame <= 1'b0;
      end
    end
  end

  // Modulation bit retimed to the carrier.
  always_ff @(posedge ck_1356meg) begin
    if (!nrst) begin
      mod_sig_coil <= 1'b0;
    end else begin
      mod_sig_coil <= ssp_dout;
    end
  end

  // Carrier gating: full carrier while listening, paused by the ARM bit when modulating.
  assign pwr_hi = ck_1356meg &
                  (((mode == MODE_MOD) & ~mod_sig_coil) | (mode == MODE_LISTEN));

endmodule

// File: tb/tb_hf_reader_rx_framer.sv
// -----------------------------------------------------------------------------
// tb_hf_reader_rx_framer
// Drives a default-parameter instance against a slot/frame-level reference
// model, plus a SC_DIV=32 / FRAME_BITS=12 instance for framing timing and
// mid-frame reset behaviour.
// -----------------------------------------------------------------------------
module tb_hf_reader_rx_framer;

  localparam int SC   = 16;
  localparam int FB   = 8;
  localparam int RP   = 3;
  localparam int P    = SC * FB;
  localparam int SC_B = 32;
  localparam int FB_B = 12;
  localparam int P_B  = SC_B * FB_B;

`ifdef HF_RX_FILTER_EN
  localparam int STEP = 2;
  localparam int PEAK = 6;
`else
  localparam int STEP = 5;
  localparam int PEAK = 5;
`endif

  logic       clk = 1'b0;
  logic       nrst;
  logic       nrst_b;
  logic [7:0] adc_d;
  logic [7:0] threshold;
  logic [2:0] mode;
  logic       ssp_dout;

  logic ssp_clk, ssp_frame, ssp_din, pwr_hi, curbit;
  logic ssp_clk_b, ssp_frame_b, ssp_din_b, pwr_hi_b, curbit_b;

  int n_tests = 0;
  int n_fail  = 0;

  // model state, instance A
  int             ta = 0;
  int             smp[$];
  logic           cb_e, din_e, clk_e, frm_e, mod_e;
  logic [FB-1:0]  cur_w, prev_w;

  // model state, instance B
  int   tb_cnt    = 0;
  int   gcyc      = 0;
  int   last_rise = -1;
  logic prev_frm_b = 1'b0;
  logic b_pulsed   = 1'b0;
  logic clk_b_e, frm_b_e, mod_b_e;

  hf_reader_rx_framer u_dut (
    .ck_1356meg (clk),
    .nrst       (nrst),
    .adc_d      (adc_d),
    .threshold  (threshold),
    .mode       (mode),
    .ssp_dout   (ssp_dout),
    .ssp_clk    (ssp_clk),
    .ssp_frame  (ssp_frame),
    .ssp_din    (ssp_din),
    .pwr_hi     (pwr_hi),
    .curbit     (curbit)
  );

  hf_reader_rx_framer #(
    .SC_DIV     (SC_B),
    .FRAME_BITS (FB_B)
  ) u_dut_b (
    .ck_1356meg (clk),
    .nrst       (nrst_b),
    .adc_d      (adc_d),
    .threshold  (threshold),
    .mode       (mode),
    .ssp_dout   (ssp_dout),
    .ssp_clk    (ssp_clk_b),
    .ssp_frame  (ssp_frame_b),
    .ssp_din    (ssp_din_b),
    .pwr_hi     (pwr_hi_b),
    .curbit     (curbit_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, cycle %0d)", tag, obs, exp, ta, gcyc);
    end
  endtask

  function automatic int xs(int k);
    return (k < 0) ? 0 : smp[k];
  endfunction

  // Filter output for the edge at index s since reset release.
  function automatic int fval(int s);
`ifdef HF_RX_FILTER_EN
    return 2 * xs(s - 4) + xs(s - 3) - 2 * xs(s) - xs(s - 1);
`else
    return xs(s - 1) - xs(s);
`endif
  endfunction

  // Decision at evaluation edge te: extremes over the edges since the last one.
  function automatic logic decide(int te, int thr);
    int hi;
    int lo;
    int first;
    int f;
    hi    = 0;
    lo    = 0;
    first = (te - SC + 1 < 0) ? 0 : te - SC + 1;
    for (int s = first; s < te; s++) begin
      f = fval(s);
      if (f > hi) hi = f;
      if (f < lo) lo = f;
    end
    return (hi > thr) && (lo < -thr);
  endfunction

  // One clock edge: update both models, then compare all outputs.
  task automatic cycle();
    int c;
    int sl;
    int b;
    nrst_b = nrst && !(tb_cnt == 200 && !b_pulsed);
    if (nrst && !nrst_b) b_pulsed = 1'b1;
    @(posedge clk);
    #1;
    gcyc++;

    if (!nrst) begin
      ta = 0;
      smp.delete();
      cb_e = 0; din_e = 0; clk_e = 0; frm_e = 0; mod_e = 0;
      cur_w = '0; prev_w = '0;
    end else begin
      smp.push_back(int'(adc_d));
      c  = ta % P;
      sl = ta % SC;
      b  = c / SC;
      if (sl == 0) begin
        if (c == 0) begin
          prev_w = cur_w;
          cur_w  = '0;
        end
        cur_w[FB-1-b] = cb_e & (mode == 3'b011);
        din_e = prev_w[FB-1-b];
      end
      if (sl == RP) cb_e = decide(ta, int'(threshold));
      clk_e = (sl < SC / 2);
      frm_e = (c >= SC / 2 - 1) && (c < SC + SC / 2 - 1);
      mod_e = ssp_dout;
      ta++;
    end

    check("curbit", curbit, cb_e);
    check("ssp_din", ssp_din, din_e);
    check("ssp_clk", ssp_clk, clk_e);
    check("ssp_frame", ssp_frame, frm_e);
    check("pwr_hi", pwr_hi, ((mode == 3'b100) && !mod_e) || (mode == 3'b011));

    if (!nrst_b) begin
      tb_cnt = 0;
      clk_b_e = 0; frm_b_e = 0; mod_b_e = 0;
      last_rise = -1;
    end else begin
      c  = tb_cnt % P_B;
      sl = c % SC_B;
      clk_b_e = (sl < SC_B / 2);
      frm_b_e = (c >= SC_B / 2 - 1) && (c < SC_B + SC_B / 2 - 1);
      mod_b_e = ssp_dout;
      if (tb_cnt < P_B) check("b_no_partial", ssp_din_b, 0);
      tb_cnt++;
    end
    check("b_ssp_clk", ssp_clk_b, clk_b_e);
    check("b_ssp_frame", ssp_frame_b, frm_b_e);
    check("b_pwr_hi", pwr_hi_b, ((mode == 3'b100) && !mod_b_e) || (mode == 3'b011));
    if (ssp_frame_b && !prev_frm_b) begin
      if (last_rise >= 0) check("b_frame_period", gcyc - last_rise, P_B);
      last_rise = gcyc;
    end
    prev_frm_b = ssp_frame_b;
  endtask

  initial begin
    logic [7:0] word1;
    logic [7:0] word3;
    int amp, half, base, noise, lvl, v, r;

    word1 = '0; word3 = '0;
    amp = 0; half = 4; base = 0; noise = 0;

    // Reset with ADC pinned high.
    nrst = 1'b0; adc_d = 8'hFF; mode = 3'b000; threshold = 8'd5; ssp_dout = 1'b0;
    repeat (5) cycle();
    check("rst_outputs", {curbit, ssp_din, ssp_clk, ssp_frame, pwr_hi}, 0);

    // Square wave for 64 edges, then constant mid-scale.
    nrst = 1'b1; mode = 3'b011; threshold = 8'd5;
    for (int i = 0; i < 512; i++) begin
      adc_d = (i < 64) ? (((i / 8) % 2 == 1) ? 8'd200 : 8'd40) : 8'd128;
      cycle();
      if (i == 0)  check("first_ssp_clk", ssp_clk, 1);
      if (i == 56) check("sq_curbit", curbit, 1);
      if (i >= 128 && i < 256 && (i % SC) == 8) word1 = {word1[6:0], ssp_din};
      if (i >= 384 && i < 512 && (i % SC) == 8) word3 = {word3[6:0], ssp_din};
      if (i == 500) check("const_curbit", curbit, 0);
    end
    check("sq_word", word1, 8'h3C);
    check("const_word", word3, 8'h00);

    // Randomised waveforms, modes, thresholds and modulation bits.
    for (int i = 0; i < 1500; i++) begin
      if (i % 48 == 0) begin
        r = int'($urandom_range(0, 5));
        mode = (r < 3) ? 3'b011 : (r == 3) ? 3'b100 : (r == 4) ? 3'b000 : 3'($urandom_range(0, 7));
        threshold = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 60));
        amp   = int'($urandom_range(0, 120));
        half  = int'($urandom_range(2, 12));
        base  = int'($urandom_range(0, 255 - amp));
        noise = int'($urandom_range(0, 6));
      end
      lvl = (((i / half) % 2) == 1) ? base + amp : base;
      v   = lvl + int'($urandom_range(0, noise));
      if (v > 255) v = 255;
      adc_d    = 8'(v);
      ssp_dout = 1'($urandom_range(0, 1));
      cycle();
    end

    // Mid-frame reset, then a step whose filter peak equals the threshold.
    nrst = 1'b0; mode = 3'b000; ssp_dout = 1'b0;
    repeat (3) cycle();
    nrst = 1'b1; mode = 3'b011; threshold = 8'(PEAK);
    for (int i = 0; i < 192; i++) begin
      if (i == 128) threshold = 8'(PEAK - 1);
      adc_d = 8'(100 + ((((i / 8) % 2) == 1) ? STEP : 0));
      cycle();
      if (i == 120) check("thr_equal_curbit", curbit, 0);
      if (i == 140) check("thr_below_curbit", curbit, 1);
    end

    // Carrier is low in the low clock phase regardless of mode.
    @(negedge clk);
    check("pwr_hi_low_phase", pwr_hi, 0);

    // Transmit gating.
    mode = 3'b100; ssp_dout = 1'b1; adc_d = 8'd128;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (k == 1) check("tx_pause", pwr_hi, 0);
    end
    ssp_dout = 1'b0;
    cycle();
    check("tx_resume", pwr_hi, 1);
    mode = 3'b000;
    for (int k = 0; k < 8; k++) begin
      ssp_dout = 1'($urandom_range(0, 1));
      cycle();
      if (k == 4) check("idle_pwr_hi", pwr_hi, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hf_reader_rx_framer.md
# hf_reader_rx_framer

Parametrised ISO14443-A reader-side receive/transmit front end in the HF FPGA image.
- Receive path: filters ADC samples and detects load modulation on the tag subcarrier (fc/SC_DIV), one bit per subcarrier period.
- Framing: packs detected bits into FRAME_BITS-wide words and streams them MSB-first to the ARM over SSP. It generates ssp_clk/ssp_frame itself.
- Transmit path: registers the ARM's modulation bit and gates the carrier on pwr_hi.
- Successor to the fixed fc/16, 8-bit, hard-threshold reader path. Adds parametrised subcarrier divisor, frame width and ADC width, a runtime threshold, and reset.

## Interface
- ADC_W, 8, ADC sample width
- SC_DIV, 16, carrier cycles per subcarrier bit slot; power of two, 8..64
- FRAME_BITS, 8, bits per SSP frame; 2..16
- RESET_PHASE, 3, slot index at which the detector evaluates and clears; must be < SC_DIV
- ck_1356meg  in  1  13.56 MHz carrier clock; all logic on its rising edge
- nrst  in  1  synchronous reset, active low
- adc_d  in  ADC_W  unsigned ADC sample
- threshold  in  ADC_W  unsigned edge threshold; must be quasi-static
- mode  in  3  3'b011 READER_LISTEN, 3'b100 READER_MOD; other values are idle
- ssp_dout  in  1  modulation bit from ARM (1 = pause)
- ssp_clk  out  1  SSP bit clock
- ssp_frame  out  1  SSP frame marker
- ssp_din  out  1  serial data to ARM
- pwr_hi  out  1  gated carrier to HF driver
- curbit  out  1  last detector decision (debug pin)

## Operation
- **Counter.** cnt has width log2(SC_DIV·FRAME_BITS) and counts 0..SC_DIV·FRAME_BITS−1, then wraps to 0. slot = cnt mod SC_DIV; bidx = cnt / SC_DIV.
- **History.** p1..p4 form a shift register of past samples: p1 ← adc_d, pN ← pN−1, every cycle.
- **Filter.** f is signed, ADC_W+3 bits, combinational: f = (2·p4 + p3) − (2·adc_d + p1). All operands are zero-extended before subtraction, so no overflow is possible (|f| ≤ 3·(2^ADC_W−1)).
- **Detector state.** Two signed registers, fall_max and rise_min.
- **Detector, slot == RESET_PHASE:**
  - curbit ← (fall_max > +threshold) && (rise_min < −threshold). Both comparisons are strict; threshold is zero-extended.
  - fall_max ← 0, rise_min ← 0.
- **Detector, all other slots:**
  - f > 0 and f > fall_max: fall_max ← f.
  - f ≤ 0 and f < rise_min: rise_min ← f.
- **Gating.** rxbit = curbit when mode == READER_LISTEN, else 0.
- **Assembly.** At slot 0: asm[FRAME_BITS−1−bidx] ← rxbit.
- **Word handoff at cnt == 0:** tx_word ← asm. The MSB write into asm in the same cycle belongs to the next word; tx_word captures the pre-update asm.
- **Serialisation.** At slot 0: ssp_din ← tx_word_next[FRAME_BITS−1−bidx], where tx_word_next is the value tx_word takes that cycle. ssp_din holds for SC_DIV cycles.
- **ssp_clk.** ← 1 at slot 0, ← 0 at slot SC_DIV/2.
- **ssp_frame.** ← 1 at cnt == SC_DIV/2−1, ← 0 at cnt == SC_DIV + SC_DIV/2 − 1.
- **Transmit.**
  - mod_sig_coil ← ssp_dout every cycle.
  - pwr_hi = ck_1356meg & ((mode == READER_MOD & ~mod_sig_coil) | mode == READER_LISTEN). This is the only combinational output.
- **Idle modes.** No pwr_hi toggling; the SSP stream continues carrying zeros.

## Timing
- **Reset (nrst low at a rising edge):**
  - cnt, p1..p4, fall_max, rise_min, asm, tx_word and mod_sig_coil clear to 0.
  - curbit, ssp_din, ssp_clk and ssp_frame clear to 0.
  - The first rising edge with nrst high sees cnt = 0.
- **Reset mid-frame.** Aborts the frame; no partial word is emitted; the counter restarts at 0.
- **Detector latency.** A sample affects f in the same cycle, fall_max/rise_min one edge later, and curbit at the next RESET_PHASE edge.
- **Word latency.** A word assembled during frame k appears on ssp_din during frame k+1, starting at cnt = 0.
- **Transmit latency.** ssp_dout reaches pwr_hi 1 cycle later.
- **Mode changes.** Take effect on the next edge; in-flight bits already in asm are kept.
- **threshold = 0.** Any non-zero edge in each direction sets curbit.

## Configuration
- HF_RX_FILTER_EN defined: 5-tap derivative filter as above.
- HF_RX_FILTER_EN undefined:
  - Filter becomes f = p1 − adc_d, same width.
  - p2..p4 are not instantiated.
  - All other behaviour is unchanged.

## Test plan
- **Reset.** Hold nrst low 5 cycles with adc_d = 8'hFF. Required: all outputs are 0. First ssp_clk rise is on the 1st edge after release; ssp_frame rises at cnt = 7 (defaults).
- **Square wave.** Defaults, mode = 3'b011, threshold = 5, adc_d alternates 8 cycles 8'd40 / 8 cycles 8'd200 for 64 cycles. Required: curbit = 1 at each RESET_PHASE. Next frame ssp_din = 1 for the corresponding 4 bit slots.
- **Constant input.** adc_d constant 8'd128. Required: curbit = 0 and all frames are 8'h00.
- **Threshold sweep.** Step amplitude giving |f| peaks of exactly 5 with threshold = 5. Required: curbit = 0 (strict comparison). With threshold = 4: curbit = 1.
- **Transmit gating.** mode = 3'b100, ssp_dout = 1 for 10 cycles. Required: pwr_hi low from the 2nd cycle; pwr_hi toggles again 1 cycle after ssp_dout = 0. With mode = 3'b000: pwr_hi is always 0.
- **Parameter sweep.** SC_DIV = 32, FRAME_BITS = 12, nrst pulsed at cnt = 200. Required: frame period is 384 cycles, ssp_frame is high over cnt 15..46, and the restart gives no partial word.
